// File: rtl/proc_bus_monitor.sv
// Passive 4-phase (FETCH/OP1/OP2/WRITE) bus checker; error pulses are registered one cycle after the offending cycle.
// Never drives or stalls the bus. Optional first-error capture ports exist when PROC_BUS_MON_FIRST_ERR_EN is defined.
module proc_bus_monitor #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int OPA_W       = 6,
    parameter int DATA_BASE   = 32,
    parameter int INSTR_DEPTH = 64,
    parameter int PC_RESET    = 0,
    parameter int CNT_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_memData,
    input  logic [DATA_W-1:0] i_cpuMemData,
    input  logic [ADDR_W-1:0] i_cpuMemAddr,
    input  logic              i_cpuMemWrEnable,
    output logic [2:0]        o_phase,
    output logic [5:0]        o_errVec,
    output logic [5:0]        o_errSticky,
    output logic [CNT_W-1:0]  o_errCount,
    output logic [CNT_W-1:0]  o_instrCount,
    output logic              o_halted
`ifdef PROC_BUS_MON_FIRST_ERR_EN
    ,
    output logic              o_firstErrValid,
    output logic [5:0]        o_firstErrVec,
    output logic [ADDR_W-1:0] o_firstErrAddr,
    output logic [2:0]        o_firstErrPhase,
    output logic [CNT_W-1:0]  o_firstErrInstr
`endif
);

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_OP1   = 3'd1,
        ST_OP2   = 3'd2,
        ST_WRITE = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(DATA_BASE);
    localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(INSTR_DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(PC_RESET);

    state_t             state_q;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [OPA_W-1:0]   op1_q, op2_q;
    logic               imm_q;
    logic [5:0]         err_q, err_d, sticky_q;
    logic [CNT_W-1:0]   ecnt_q, icnt_q;
    logic               halted_q;
    logic [ADDR_W-1:0]  op1_addr, op2_addr;

    assign op1_addr = ADDR_W'(op1_q);
    assign op2_addr = ADDR_W'(op2_q);
    assign pc_d     = (pc_q == PC_LAST) ? '0 : pc_q + ADDR_W'(1);

    // All checks look at this cycle's bus only; the result is registered below.
    always_comb begin
        err_d    = '0;
        err_d[5] = (state_q == ST_WRITE) ? !i_cpuMemWrEnable : i_cpuMemWrEnable;
        err_d[0] = (state_q != ST_WRITE) && (i_cpuMemData != '0);
        case (state_q)
            ST_FETCH: err_d[2] = (i_cpuMemAddr != pc_q);
            ST_OP1:   err_d[3] = (i_cpuMemAddr != op1_addr) || (op1_addr < BASE_A);
            ST_OP2:   err_d[4] = !imm_q && ((i_cpuMemAddr != op2_addr) || (op2_addr < BASE_A));
            ST_WRITE: err_d[1] = (i_cpuMemAddr != op1_addr);
            default:  ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= PC_RST;
            op1_q    <= '0;
            op2_q    <= '0;
            imm_q    <= 1'b0;
            err_q    <= '0;
            sticky_q <= '0;
            ecnt_q   <= '0;
            icnt_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            err_q    <= err_d;
            sticky_q <= sticky_q | err_d;
            if ((|err_d) && (ecnt_q != '1))
                ecnt_q <= ecnt_q + CNT_W'(1);
            // Frame advances unconditionally; errors never resynchronise it.
            case (state_q)
                ST_FETCH: begin
                    imm_q <= i_memData[DATA_W-1];
                    op1_q <= i_memData[2*OPA_W-1:OPA_W];
                    op2_q <= i_memData[OPA_W-1:0];
                    pc_q  <= pc_d;
                    if (i_memData == '0) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q  <= ST_OP1;
                    end
                end
                ST_OP1:   state_q <= ST_OP2;
                ST_OP2:   state_q <= ST_WRITE;
                ST_WRITE: begin
                    state_q <= ST_FETCH;
                    if (icnt_q != '1)
                        icnt_q <= icnt_q + CNT_W'(1);
                end
                ST_HALT:  state_q <= ST_HALT;
                default:  state_q <= ST_FETCH;
            endcase
        end
    end

    assign o_phase      = state_q;
    assign o_errVec     = err_q;
    assign o_errSticky  = sticky_q;
    assign o_errCount   = ecnt_q;
    assign o_instrCount = icnt_q;
    assign o_halted     = halted_q;

`ifdef PROC_BUS_MON_FIRST_ERR_EN
    logic              fe_vld_q;
    logic [5:0]        fe_vec_q;
    logic [ADDR_W-1:0] fe_addr_q;
    logic [2:0]        fe_phase_q;
    logic [CNT_W-1:0]  fe_instr_q;

    // Captured in the same edge that registers the first error pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fe_vld_q   <= 1'b0;
            fe_vec_q   <= '0;
            fe_addr_q  <= '0;
            fe_phase_q <= '0;
            fe_instr_q <= '0;
        end else if ((|err_d) && !fe_vld_q) begin
            fe_vld_q   <= 1'b1;
            fe_vec_q   <= err_d;
            fe_addr_q  <= i_cpuMemAddr;
            fe_phase_q <= state_q;
            fe_instr_q <= icnt_q;
        end
    end

    assign o_firstErrValid = fe_vld_q;
    assign o_firstErrVec   = fe_vec_q;
    assign o_firstErrAddr  = fe_addr_q;
    assign o_firstErrPhase = fe_phase_q;
    assign o_firstErrInstr = fe_instr_q;
`endif

endmodule

// File: tb/tb_proc_bus_monitor.sv
// Self-checking bench for proc_bus_monitor: directed table, wrap sequences and randomized frames vs a reference model.
module tb_proc_bus_monitor;

    localparam int DEPTH = 64;
    localparam int BASE  = 32;

    logic        i_clk, i_rst, i_cpuMemWrEnable;
    logic [15:0] i_memData, i_cpuMemData, i_cpuMemAddr;
    logic [2:0]  o_phase;
    logic [5:0]  o_errVec, o_errSticky;
    logic [15:0] o_errCount, o_instrCount;
    logic        o_halted;
`ifdef PROC_BUS_MON_FIRST_ERR_EN
    logic        o_firstErrValid;
    logic [5:0]  o_firstErrVec;
    logic [15:0] o_firstErrAddr;
    logic [2:0]  o_firstErrPhase;
    logic [15:0] o_firstErrInstr;
`endif

    proc_bus_monitor dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_memData(i_memData), .i_cpuMemData(i_cpuMemData),
        .i_cpuMemAddr(i_cpuMemAddr), .i_cpuMemWrEnable(i_cpuMemWrEnable),
        .o_phase(o_phase), .o_errVec(o_errVec), .o_errSticky(o_errSticky),
        .o_errCount(o_errCount), .o_instrCount(o_instrCount), .o_halted(o_halted)
`ifdef PROC_BUS_MON_FIRST_ERR_EN
        , .o_firstErrValid(o_firstErrValid), .o_firstErrVec(o_firstErrVec),
        .o_firstErrAddr(o_firstErrAddr), .o_firstErrPhase(o_firstErrPhase),
        .o_firstErrInstr(o_firstErrInstr)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: frame position 0..3 (FETCH, OP1, OP2, WRITE) or 4 once halted.
    int m_ph, m_pc, m_instr, m_op1, m_vec, m_sticky, m_ecnt, m_icnt, m_halt;
    int m_fe_vld, m_fe_vec, m_fe_addr, m_fe_ph, m_fe_ins;

    task automatic model_step(input logic rst, input logic [15:0] mem, wdat, addr, input logic we);
        int e, ph0, ic0, op2;
        if (rst) begin
            m_ph = 0; m_pc = 0; m_instr = 0; m_op1 = 0; m_vec = 0; m_sticky = 0;
            m_ecnt = 0; m_icnt = 0; m_halt = 0;
            m_fe_vld = 0; m_fe_vec = 0; m_fe_addr = 0; m_fe_ph = 0; m_fe_ins = 0;
            return;
        end
        e = 0; ph0 = m_ph; ic0 = m_icnt;
        if ((m_ph == 3) != (we == 1'b1)) e |= 32;
        if (m_ph != 3 && wdat != 0) e |= 1;
        if (m_ph == 0) begin
            if (int'(addr) != m_pc) e |= 4;
            m_pc = (m_pc + 1) % DEPTH;
            m_instr = int'(mem);
            m_op1 = (m_instr / 64) % 64;
            if (mem == 0) begin m_ph = 4; m_halt = 1; end
            else m_ph = 1;
        end else if (m_ph == 1) begin
            if (int'(addr) != m_op1 || m_op1 < BASE) e |= 8;
            m_ph = 2;
        end else if (m_ph == 2) begin
            op2 = m_instr % 64;
            if (m_instr < 32768 && (int'(addr) != op2 || op2 < BASE)) e |= 16;
            m_ph = 3;
        end else if (m_ph == 3) begin
            if (int'(addr) != m_op1) e |= 2;
            if (m_icnt < 65535) m_icnt++;
            m_ph = 0;
        end
        if (e != 0 && m_fe_vld == 0) begin
            m_fe_vld = 1; m_fe_vec = e; m_fe_addr = int'(addr); m_fe_ph = ph0; m_fe_ins = ic0;
        end
        m_vec = e;
        m_sticky |= e;
        if (e != 0 && m_ecnt < 65535) m_ecnt++;
    endtask

    task automatic cyc(input logic rst, input logic [15:0] mem, wdat, addr, input logic we);
        i_rst = rst; i_memData = mem; i_cpuMemData = wdat; i_cpuMemAddr = addr; i_cpuMemWrEnable = we;
        model_step(rst, mem, wdat, addr, we);
        @(posedge i_clk);
        #1;
        chk("phase",      32'(o_phase),      32'(m_ph));
        chk("errVec",     32'(o_errVec),     32'(m_vec));
        chk("errSticky",  32'(o_errSticky),  32'(m_sticky));
        chk("errCount",   32'(o_errCount),   32'(m_ecnt));
        chk("instrCount", 32'(o_instrCount), 32'(m_icnt));
        chk("halted",     32'(o_halted),     32'(m_halt));
`ifdef PROC_BUS_MON_FIRST_ERR_EN
        chk("feValid", 32'(o_firstErrValid), 32'(m_fe_vld));
        chk("feVec",   32'(o_firstErrVec),   32'(m_fe_vec));
        chk("feAddr",  32'(o_firstErrAddr),  32'(m_fe_addr));
        chk("fePhase", 32'(o_firstErrPhase), 32'(m_fe_ph));
        chk("feInstr", 32'(o_firstErrInstr), 32'(m_fe_ins));
`endif
    endtask

    task automatic legal_frames(input int n);
        for (int f = 0; f < n; f++) begin
            cyc(1'b0, 16'h0820, 16'h0, 16'(f % DEPTH), 1'b0);
            cyc(1'b0, 16'h1111, 16'h0, 16'd32, 1'b0);
            cyc(1'b0, 16'h2222, 16'h0, 16'd32, 1'b0);
            cyc(1'b0, 16'h3333, 16'h5A5A, 16'd32, 1'b1);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [15:0] mem;
        logic [15:0] wdat;
        logic [15:0] addr;
        logic        we;
        logic [5:0]  exp_err;
        int          exp_ecnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [15:0] mem, wdat, addr, input logic we,
                       input logic [5:0] ee, input int ec);
        vec_t v;
        v.rst = rst; v.mem = mem; v.wdat = wdat; v.addr = addr; v.we = we;
        v.exp_err = ee; v.exp_ecnt = ec;
        tbl.push_back(v);
    endtask

    initial begin
        logic [15:0] mem, wdat, addr;
        logic        we;
        i_rst = 1'b1; i_memData = '0; i_cpuMemData = '0; i_cpuMemAddr = '0; i_cpuMemWrEnable = 1'b0;

        // Legal program ending in halt, then errors while halted.
        add(1, 16'h0000, 16'h0000, 16'd0,  0, 6'b000000, 0);
        add(0, 16'h0820, 16'h0000, 16'd0,  0, 6'b000000, 0);
        add(0, 16'h0000, 16'h0000, 16'd32, 0, 6'b000000, 0);
        add(0, 16'h0000, 16'h0000, 16'd32, 0, 6'b000000, 0);
        add(0, 16'h0000, 16'h1234, 16'd32, 1, 6'b000000, 0);
        add(0, 16'h8860, 16'h0000, 16'd1,  0, 6'b000000, 0);
        add(0, 16'h0000, 16'h0000, 16'd33, 0, 6'b000000, 0);
        add(0, 16'h0000, 16'h0000, 16'h55, 0, 6'b000000, 0);
        add(0, 16'h0000, 16'hABCD, 16'd33, 1, 6'b000000, 0);
        add(0, 16'h0C30, 16'h0000, 16'd2,  0, 6'b000000, 0);
        add(0, 16'h0000, 16'h0000, 16'd48, 0, 6'b000000, 0);
        add(0, 16'h0000, 16'h0000, 16'd48, 0, 6'b000000, 0);
        add(0, 16'h0000, 16'h0001, 16'd48, 1, 6'b000000, 0);
        add(0, 16'h0000, 16'h0000, 16'd3,  0, 6'b000000, 0);
        add(0, 16'h0000, 16'h0001, 16'h999, 1, 6'b100001, 1);
        add(0, 16'h0000, 16'h0000, 16'h123, 0, 6'b000000, 1);
        // Operand below base, immediate skip, OP2 violation, write protocol.
        add(1, 16'h0000, 16'h0000, 16'd0,  0, 6'b000000, 0);
        add(0, 16'h0160, 16'h0000, 16'd0,  0, 6'b000000, 0);
        add(0, 16'h0000, 16'h0000, 16'd5,  0, 6'b001000, 1);
        add(0, 16'h0000, 16'h0000, 16'd32, 0, 6'b000000, 1);
        add(0, 16'h0000, 16'h0000, 16'd5,  1, 6'b000000, 1);
        add(0, 16'h8805, 16'h0000, 16'd1,  0, 6'b000000, 1);
        add(0, 16'h0000, 16'h0000, 16'd32, 0, 6'b000000, 1);
        add(0, 16'h0000, 16'h0000, 16'd7,  0, 6'b000000, 1);
        add(0, 16'h0000, 16'h0000, 16'd32, 1, 6'b000000, 1);
        add(0, 16'h0805, 16'h0000, 16'd2,  0, 6'b000000, 1);
        add(0, 16'h0000, 16'h0000, 16'd32, 0, 6'b000000, 1);
        add(0, 16'h0000, 16'h0000, 16'd7,  0, 6'b010000, 2);
        add(0, 16'h0000, 16'h0000, 16'd32, 1, 6'b000000, 2);
        add(0, 16'h0820, 16'h0000, 16'd3,  0, 6'b000000, 2);
        add(0, 16'h0000, 16'h0042, 16'd32, 0, 6'b000001, 3);
        add(0, 16'h0000, 16'h0000, 16'd32, 1, 6'b100000, 4);
        add(0, 16'h0000, 16'h0000, 16'd33, 1, 6'b000010, 5);
        add(0, 16'h0820, 16'h0000, 16'd5,  0, 6'b000100, 6);
        add(0, 16'h0000, 16'h0007, 16'd32, 1, 6'b100001, 7);
        // Reset while in OP2, then fetch at PC_RESET.
        add(1, 16'h0000, 16'h0000, 16'd32, 0, 6'b000000, 0);
        add(0, 16'h0820, 16'h0000, 16'd0,  0, 6'b000000, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].mem, tbl[i].wdat, tbl[i].addr, tbl[i].we);
            chk($sformatf("tbl%0d_errVec", i), 32'(o_errVec), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_errCount", i), 32'(o_errCount), 32'(tbl[i].exp_ecnt));
            if (i == 14) begin
                chk("legal_instrCount", 32'(o_instrCount), 32'd3);
                chk("legal_halted", 32'(o_halted), 32'd1);
            end
            if (i == 18) chk("base_sticky3", 32'(o_errSticky[3]), 32'd1);
            if (i == 35) chk("midreset_sticky", 32'(o_errSticky), 32'd0);
        end

        // PC wraps from INSTR_DEPTH-1 back to 0.
        cyc(1'b1, 16'h0, 16'h0, 16'h0, 1'b0);
        legal_frames(DEPTH);
        cyc(1'b0, 16'h0820, 16'h0, 16'd0, 1'b0);
        chk("wrap_noE2", 32'(o_errVec), 32'd0);
        chk("wrap_instrCount", 32'(o_instrCount), 32'(DEPTH));
        cyc(1'b1, 16'h0, 16'h0, 16'h0, 1'b0);
        legal_frames(DEPTH);
        cyc(1'b0, 16'h0820, 16'h0, 16'd64, 1'b0);
        chk("pc64_E2", 32'(o_errVec), 32'b000100);

        // Randomized frames with sparse fault injection and occasional resets.
        cyc(1'b1, 16'h0, 16'h0, 16'h0, 1'b0);
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 99) == 0 || (m_ph == 4 && $urandom_range(0, 7) == 0)) begin
                cyc(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
                continue;
            end
            mem = 16'($urandom); wdat = 16'h0; we = 1'b0; addr = 16'($urandom);
            case (m_ph)
                0: begin
                    mem[11:6] = 6'($urandom_range(26, 63));
                    mem[5:0]  = 6'($urandom_range(26, 63));
                    if ($urandom_range(0, 29) == 0) mem = 16'h0;
                    addr = 16'(m_pc);
                end
                1: addr = 16'(m_op1);
                2: if (m_instr < 32768) addr = 16'(m_instr % 64);
                3: begin addr = 16'(m_op1); we = 1'b1; wdat = 16'($urandom); end
                default: ;
            endcase
            if ($urandom_range(0, 9) == 0) addr = addr ^ (16'h1 << $urandom_range(0, 15));
            if ($urandom_range(0, 11) == 0) we = !we;
            if ($urandom_range(0, 11) == 0) wdat = 16'($urandom_range(1, 65535));
            cyc(1'b0, mem, wdat, addr, we);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
